// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the 12-bit sequence detector.
// Takes one WIDTH-bit word per valid/ready handshake and emits it one bit per
// clock on x_o. Words stream back-to-back with no idle gap. The framing outputs
// bit_valid_o and last_o are registered alongside x_o.
module seq_serializer #(
   parameter int unsigned WIDTH     = 12,
   parameter bit          MSB_FIRST = 1'b0,
   parameter logic        IDLE_BIT  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             x_o,
   output logic             bit_valid_o,
   output logic             last_o,
   output logic             busy_o
);

   localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_inc;
   logic             accept;
   logic             first_bit;
   logic             next_bit;

   // Ready depends only on registered state, so there is no path from valid to ready.
   assign ready_o = (state == IDLE) || ((state == SHIFT) && (cnt == LAST_IDX));
   assign accept  = valid_i && ready_o;
   assign busy_o  = (state == SHIFT);

   // Select the first bit of an incoming word and the next bit of the word in flight.
   always_comb begin
      cnt_inc   = cnt + 1'b1;
      first_bit = MSB_FIRST ? data_i[WIDTH-1] : data_i[0];
      next_bit  = MSB_FIRST ? sr[LAST_IDX - cnt_inc] : sr[cnt_inc];
   end

   // Control FSM, shift register and registered serial outputs.
   // An accept is handled identically whether it happens in IDLE or on the
   // last-bit cycle of SHIFT, so both share one branch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         sr          <= '0;
         cnt         <= '0;
         x_o         <= IDLE_BIT;
         bit_valid_o <= 1'b0;
         last_o      <= 1'b0;
      end else if (accept) begin
         state       <= SHIFT;
         sr          <= data_i;
         cnt         <= '0;
         x_o         <= first_bit;
         bit_valid_o <= 1'b1;
         last_o      <= 1'b0;
      end else if (state == SHIFT) begin
         if (cnt != LAST_IDX) begin
            cnt         <= cnt_inc;
            x_o         <= next_bit;
            bit_valid_o <= 1'b1;
            last_o      <= (cnt_inc == LAST_IDX);
         end else begin
            state       <= IDLE;
            cnt         <= '0;
            x_o         <= IDLE_BIT;
            bit_valid_o <= 1'b0;
            last_o      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: self-checking bench for seq_serializer.
// A queue-based reference model holds the bits still to appear on x_o, which
// gives the expected serial output, framing and handshake for every cycle.
module tb_seq_serializer;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] data  = '0;
   logic        valid = 1'b0;
   logic        ready, x, bv, last, busy;

   logic [3:0]  data4  = '0;
   logic        valid4 = 1'b0;
   logic        ready4, x4, bv4, last4, busy4;

   int errors = 0;
   int checks = 0;

   // Reference model: mq[0] is the bit currently on x_o, the rest follow in order.
   bit          mq[$];
   bit          acc_last;
   logic [11:0] wq[$];
   logic [11:0] got_w;
   bit          exp4[4];

   always #5 clk = ~clk;

   seq_serializer u_dut (
      .clk         (clk),
      .reset       (reset),
      .data_i      (data),
      .valid_i     (valid),
      .ready_o     (ready),
      .x_o         (x),
      .bit_valid_o (bv),
      .last_o      (last),
      .busy_o      (busy)
   );

   seq_serializer #(
      .WIDTH     (4),
      .MSB_FIRST (1'b1),
      .IDLE_BIT  (1'b1)
   ) u_dut4 (
      .clk         (clk),
      .reset       (reset),
      .data_i      (data4),
      .valid_i     (valid4),
      .ready_o     (ready4),
      .x_o         (x4),
      .bit_valid_o (bv4),
      .last_o      (last4),
      .busy_o      (busy4)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model update at a rising edge: the shown bit retires, and an accepted word
   // appends its WIDTH bits in LSB-first order.
   task automatic model_edge();
      bit rdy;
      acc_last = 1'b0;
      if (reset) begin
         rdy = (mq.size() <= 1);
         if (mq.size() > 0) mq.delete(0);
         if (valid && rdy) begin
            for (int i = 0; i < 12; i++) mq.push_back(data[i]);
            acc_last = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      check_val("x_o",         x,     (mq.size() > 0) ? mq[0] : 1'b1);
      check_val("bit_valid_o", bv,    mq.size() > 0);
      check_val("last_o",      last,  mq.size() == 1);
      check_val("busy_o",      busy,  mq.size() > 0);
      check_val("ready_o",     ready, mq.size() <= 1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bv_run;
      int rdy_hi;
      int waited;

      // Reset held with a word pending: nothing consumed, idle outputs.
      reset = 1'b0;
      valid = 1'b1;
      data  = 12'hEDB;
      repeat (3) tick();
      check_val("rst_x4",  x4,  1);
      check_val("rst_bv4", bv4, 0);

      // Release: the pending word is accepted on the first edge.
      reset = 1'b1;
      tick();
      check_val("accept_first_edge", busy, 1);
      valid = 1'b0;
      got_w[0] = x;
      for (int k = 1; k < 12; k++) begin
         tick();
         got_w[k] = x;
         check_val("single_last", last, k == 11);
      end
      check_val("single_word_bits", got_w, 12'b1110_1101_1011);
      tick();
      check_val("idle_after_x",  x,  1);
      check_val("idle_after_bv", bv, 0);

      // Back-to-back streaming with valid held high.
      wq.push_back(12'hEDB);
      wq.push_back(12'h5A3);
      valid  = 1'b1;
      data   = wq[0];
      bv_run = 0;
      rdy_hi = 0;
      for (int c = 0; c < 40 && (wq.size() > 0 || bv); c++) begin
         tick();
         if (acc_last) begin
            wq.delete(0);
            if (wq.size() > 0) data = wq[0];
            else valid = 1'b0;
         end
         if (bv) bv_run++;
         if (bv && ready) rdy_hi++;
      end
      check_val("b2b_all_accepted", wq.size(), 0);
      check_val("b2b_payload_cycles", bv_run, 24);
      check_val("b2b_ready_in_flight", rdy_hi, 2);

      // Back-pressure: a word offered at bit 4 waits for the last-bit edge.
      valid = 1'b1;
      data  = 12'h5A3;
      tick();
      valid = 1'b0;
      repeat (4) tick();
      valid = 1'b1;
      data  = 12'h123;
      tick();
      check_val("bp_not_ready", ready, 0);
      data   = 12'hFFF;
      waited = 0;
      for (int c = 0; c < 20 && !acc_last; c++) begin
         tick();
         waited++;
      end
      check_val("bp_accept_edge", waited, 7);
      valid = 1'b0;
      got_w[0] = x;
      for (int k = 1; k < 12; k++) begin
         tick();
         got_w[k] = x;
      end
      check_val("bp_word_bits", got_w, 12'hFFF);
      tick();

      // Asynchronous reset between edges while bit 5 is on x_o.
      valid = 1'b1;
      data  = 12'h0F0;
      tick();
      valid = 1'b0;
      repeat (5) tick();
      #2 reset = 1'b0;
      #1;
      mq.delete();
      check_outputs();
      check_val("midrst_x",    x,    1);
      check_val("midrst_bv",   bv,   0);
      check_val("midrst_busy", busy, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (15) tick();

      // Randomized traffic; the source holds data stable until accepted.
      for (int c = 0; c < 400; c++) begin
         if (!valid || acc_last) begin
            valid = ($urandom_range(0, 3) != 0);
            data  = 12'($urandom);
         end
         tick();
      end
      valid = 1'b0;
      repeat (15) tick();

      // WIDTH=4, MSB first: 4'b1000 goes out as 1,0,0,0.
      exp4  = '{1'b1, 1'b0, 1'b0, 1'b0};
      data4  = 4'b1000;
      valid4 = 1'b1;
      tick();
      valid4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_val("w4_x",    x4,    exp4[k]);
         check_val("w4_last", last4, k == 3);
         check_val("w4_bv",   bv4,   1);
         if (k < 3) tick();
      end
      tick();
      check_val("w4_idle_x",     x4,     1);
      check_val("w4_idle_bv",    bv4,    0);
      check_val("w4_idle_busy",  busy4,  0);
      check_val("w4_idle_ready", ready4, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the 12-bit sequence detector. It accepts a parallel pattern word over a valid/ready handshake and emits it one bit per clock on `x_o`, which wires directly to the detector's serial input `x_i`. Back-to-back words stream with no idle gap, so a pattern can straddle word boundaries exactly as it would on a live serial line. Framing side-band (`bit_valid_o`, `last_o`) supports bench scoreboarding and gating of downstream logic.

## Interface

Parameters:
- `WIDTH`, 12: bits per word; legal range is `WIDTH` >= 2.
- `MSB_FIRST`, 0: 0 sends `data_i[0]` first; 1 sends `data_i[WIDTH-1]` first.
- `IDLE_BIT`, 1'b1: value driven on `x_o` when no word is being sent.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `data_i`  input  WIDTH  parallel word; captured only on handshake.
- `valid_i`  input  1  `data_i` is valid.
- `ready_o`  output  1  block can accept a word this cycle.
- `x_o`  output  1  serial bit to the detector (`x_i`); registered.
- `bit_valid_o`  output  1  `x_o` carries a payload bit this cycle; registered.
- `last_o`  output  1  `x_o` is the final bit of the current word; registered.
- `busy_o`  output  1  a word is in flight (high in the SHIFT state).

## Operation

- FSM with two states, IDLE and SHIFT, plus a WIDTH-bit shift register `sr` and a bit counter `cnt` of width $clog2(WIDTH).
- Handshake: a word is accepted on a rising edge where `valid_i && ready_o`. The `data_i` value is captured at that edge only; changes at any other time are ignored.
- `ready_o` is combinational: `(state==IDLE) || (state==SHIFT && cnt==WIDTH-1)`. It is never gated by `valid_i`, so there is no combinational path from valid to ready.
- IDLE:
  - Outputs: `x_o`=`IDLE_BIT`, `bit_valid_o`=0, `last_o`=0.
  - On accept: load `sr`, set `cnt`=0, drive the first bit on `x_o`, move to SHIFT.
- SHIFT, each edge:
  - If `cnt` < WIDTH-1: `cnt` increments and the next bit is driven.
  - If `cnt`==WIDTH-1 with an accept on that edge: reload `sr`, set `cnt`=0 and drive the new word's first bit. The state stays SHIFT.
  - If `cnt`==WIDTH-1 without an accept: return to IDLE.
- Bit order: with `MSB_FIRST`=0 the bits go `data_i[0]`, `data_i[1]`, …, `data_i[WIDTH-1]`. With `MSB_FIRST`=1 the order is reversed.
- `last_o`=1 exactly when `bit_valid_o`=1 and the bit on `x_o` is bit index WIDTH-1 of the transmit order.
- Reset mid-word: the partial word is discarded and all outputs return to their reset values immediately (asynchronous). No bits resume after reset is released.
- `valid_i` while not ready: the word is held off. The block does not buffer it; the source must keep `valid_i` and `data_i` stable until accepted.

## Timing

- Reset values:
  - state = IDLE, `cnt`=0, `sr`=0.
  - `x_o`=`IDLE_BIT`, `bit_valid_o`=0, `last_o`=0, `busy_o`=0.
  - `ready_o` reads 1 while `reset`=0, but the handshake has no effect until `reset` is released.
- Latency: a word accepted at edge N puts its first bit on `x_o` from edge N until edge N+1. The detector samples that bit at edge N+1.
- Each word occupies exactly WIDTH consecutive cycles on `x_o`.
- Throughput: one bit per cycle. Sustained streaming is achieved when `valid_i` is high during every last-bit cycle; there are zero idle cycles between words.
- Minimum gap on the idle path: after the last bit, if no word arrives, `x_o` shows `IDLE_BIT` from the next edge onward.
- `busy_o` follows the state register: it rises at the accept edge and falls at the edge that leaves SHIFT.

## Test plan

- Reset: hold `reset`=0 for 3 cycles with `valid_i`=1.
  - Required: `x_o`=1, `bit_valid_o`=0, `last_o`=0, `busy_o`=0 throughout, and no word is consumed.
  - After release, the pending word is accepted on the first edge.
- Single word: `data_i`=12'b1110_1101_1011 (`MSB_FIRST`=0) accepted at edge N.
  - Required `x_o` over edges N..N+11: 1,1,0,1,1,0,1,1,0,1,1,1.
  - `last_o`=1 only on the 12th bit; `x_o`=1 and `bit_valid_o`=0 from edge N+12.
  - With `x_o` wired to the detector, `det_o` fires per the detector's spec for this pattern.
- Back-to-back: two words, 12'hEDB then 12'h5A3, with `valid_i` held high.
  - Required: 24 consecutive payload bits and `bit_valid_o` high for 24 cycles with no gap.
  - `ready_o` is high only in the IDLE cycle and on the two last-bit cycles.
- Back-pressure: assert `valid_i` with 12'hFFF at bit 4 of a word in flight.
  - Required: `ready_o`=0 until the last-bit cycle; the word is accepted on that edge, and its bits follow with no gap.
  - Changes to `data_i` before acceptance are not transmitted.
- Reset mid-word: assert `reset`=0 asynchronously, between edges, while bit 5 is on `x_o`.
  - Required: outputs return to reset values immediately.
  - After release, `x_o` stays at `IDLE_BIT` until a new accept, and no remaining bits of the aborted word appear.
- `MSB_FIRST`=1, `WIDTH`=4: `data_i`=4'b1000.
  - Required: `x_o` = 1,0,0,0, with `last_o` on the 4th bit.
